// File: rtl/mul_result_bcd.sv
// Binary-to-packed-BCD converter (sequential double-dabble) for the multiplier result display.
// Define BCD_SEG_OUT_EN to add a registered 7-segment output alongside bcd_out.
module mul_result_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  overrun
`ifdef BCD_SEG_OUT_EN
    ,
    output logic [7*DIGITS-1:0]   seg_out
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic                in_valid_d;
    logic                trig;
    logic [WIDTH-1:0]    bin_reg;
    logic [4*DIGITS-1:0] bcd_reg;
    logic [4*DIGITS-1:0] bcd_adj;
    logic [CNT_W-1:0]    cnt;
    logic                last_iter;
    logic                busy_nxt;
    logic                out_valid_nxt;
    logic                overrun_nxt;

    // Rising edge of the multiplier's valid; a held level triggers only once.
    assign trig      = in_valid & ~in_valid_d;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd_reg);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig) state_nxt = SHIFT;
            SHIFT:   if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt      = (state_nxt != IDLE);
        out_valid_nxt = (state == DONE);
        overrun_nxt   = overrun | (trig && (state != IDLE));
    end

`ifdef BCD_SEG_OUT_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    logic [7*DIGITS-1:0] seg_nxt;

    always_comb begin
        seg_nxt = '0;
        for (int i = 0; i < DIGITS; i++) seg_nxt[7*i +: 7] = seg7(bcd_reg[4*i +: 4]);
    end

    always_ff @(posedge clk) begin
        if (rst)                seg_out <= '0;
        else if (state == DONE) seg_out <= seg_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_d <= 1'b0;
            bin_reg    <= '0;
            bcd_reg    <= '0;
            cnt        <= '0;
            bcd_out    <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            in_valid_d <= in_valid;
            out_valid  <= out_valid_nxt;
            busy       <= busy_nxt;
            overrun    <= overrun_nxt;
            case (state)
                IDLE: if (trig) begin
                    bin_reg <= in_data;
                    bcd_reg <= '0;
                    cnt     <= '0;
                end
                SHIFT: begin
                    // Binary MSB shifts into the adjusted BCD LSB.
                    bcd_reg <= {bcd_adj[4*DIGITS-2:0], bin_reg[WIDTH-1]};
                    bin_reg <= {bin_reg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt + 1'b1;
                end
                DONE:    bcd_out <= bcd_reg;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_result_bcd.sv
// Self-checking bench for mul_result_bcd: vector table plus hand sequences for held valid,
// overrun, trigger at DONE and reset mid-conversion.
module tb_mul_result_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [11:0] bcd_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;
`ifdef BCD_SEG_OUT_EN
    logic [20:0] seg_out;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    mul_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
`ifdef BCD_SEG_OUT_EN
        ,
        .seg_out   (seg_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic [11:0] exp_bcd;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge; also counts out_valid pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (out_valid) pulses++;
    endtask

    // Ticks until out_valid, returning edges taken (bounded).
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic convert(input logic [7:0] d, input logic [11:0] exp, input logic exp_ovr,
                           input string name);
        int n;
        int p0;
        p0       = pulses;
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({name, " busy"}, 32'(busy), 32'd1);
        wait_out(n);
        check({name, " latency"}, 32'(n), 32'd9);
        check({name, " bcd"}, 32'(bcd_out), 32'(exp));
        check({name, " overrun"}, 32'(overrun), 32'(exp_ovr));
        tick();
        check({name, " pulse width"}, 32'(out_valid), 32'd0);
        check({name, " idle"}, 32'(busy), 32'd0);
        check({name, " pulse count"}, 32'(pulses - p0), 32'd1);
        tick();
    endtask

    initial begin
        vec_t vecs[7];
        int   n;
        int   p0;

        vecs[0] = '{8'd225, 12'h225};
        vecs[1] = '{8'd0,   12'h000};
        vecs[2] = '{8'd255, 12'h255};
        vecs[3] = '{8'd1,   12'h001};
        vecs[4] = '{8'd99,  12'h099};
        vecs[5] = '{8'd128, 12'h128};
        vecs[6] = '{8'd200, 12'h200};

        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        tick();
        tick();
        check("reset bcd", 32'(bcd_out), 32'h0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            convert(vecs[i].data, vecs[i].exp_bcd, 1'b0, $sformatf("vec%0d", i));
        end

        // Held valid yields exactly one conversion and no overrun.
        p0       = pulses;
        in_data  = 8'd42;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("held pulses", 32'(pulses - p0), 32'd1);
        check("held bcd", 32'(bcd_out), 32'h042);
        check("held overrun", 32'(overrun), 32'd0);

        // Second edge 3 cycles into a conversion is dropped and flagged.
        p0       = pulses;
        in_data  = 8'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_data  = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ovr flag", 32'(overrun), 32'd1);
        wait_out(n);
        check("ovr bcd", 32'(bcd_out), 32'h100);
        tick();
        tick();
        check("ovr pulses", 32'(pulses - p0), 32'd1);
        convert(8'd7, 12'h007, 1'b1, "after ovr");

        // Reset on the 4th SHIFT cycle aborts; held valid restarts after release.
        p0       = pulses;
        in_data  = 8'd196;
        in_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort busy", 32'(busy), 32'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort bcd", 32'(bcd_out), 32'h0);
        check("abort overrun", 32'(overrun), 32'd0);
        check("abort pulses", 32'(pulses - p0), 32'd0);
        rst = 1'b0;
        tick();
        check("restart busy", 32'(busy), 32'd1);
        wait_out(n);
        check("restart latency", 32'(n), 32'd9);
        check("restart bcd", 32'(bcd_out), 32'h196);
`ifdef BCD_SEG_OUT_EN
        check("restart seg", 32'(seg_out), 32'({7'h06, 7'h6F, 7'h7D}));
`endif
        in_valid = 1'b0;
        tick();
        tick();

        // Edge sampled while in DONE is dropped and counted as overrun.
        in_data  = 8'd50;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        in_data  = 8'd77;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("done-edge out_valid", 32'(out_valid), 32'd1);
        check("done-edge bcd", 32'(bcd_out), 32'h050);
        check("done-edge overrun", 32'(overrun), 32'd1);
        tick();
        check("done-edge dropped", 32'(busy), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("done-edge bcd hold", 32'(bcd_out), 32'h050);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
